// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b computed one bit per clock through
// a half-subtractor cell and a registered borrow, with valid/ready on both sides.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out,
    output logic             busy_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             br_q,     br_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;
    logic             ready_q,  ready_d;
    logic             valid_q,  valid_d;
    logic             busy_q,   busy_d;

    logic hs_diff;
    logic hs_borrow;
    logic diff_bit;
    logic br_next;

    // Half-subtractor on the current LSBs, then fold in the registered borrow
    always_comb begin
        hs_diff   = a_q[0] ^ b_q[0];
        hs_borrow = ~a_q[0] & b_q[0];
        diff_bit  = hs_diff ^ br_q;
        br_next   = hs_borrow | (~hs_diff & br_q);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            S_IDLE: begin
                if (valid_in && ready_q) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = (res_q >> 1) | (WIDTH'(diff_bit) << (WIDTH - 1));
                br_d  = br_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    diff_d   = res_d;
                    borrow_d = br_next;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (valid_q && ready_in) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake flags track the upcoming state so they are registered, not decoded
        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_DONE);
        busy_d  = (state_d == S_RUN);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign ready_out  = ready_q;
    assign valid_out  = valid_q;
    assign busy_out   = busy_q;
    assign diff_out   = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: WIDTH=1, 8 and 13 instances, directed
// cases on the 8-bit instance, then randomized traffic on all three in parallel.
module tb_serial_subtractor;

    localparam int unsigned MAXW = 13;
    localparam int unsigned MW1  = MAXW + 1;
    localparam int unsigned WS [3] = '{1, 8, 13};

    typedef struct packed {
        logic [MAXW-1:0] diff;
        logic            borrow;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            valid_in   [3];
    logic            ready_out  [3];
    logic [MAXW-1:0] a_in       [3];
    logic [MAXW-1:0] b_in       [3];
    logic            valid_out  [3];
    logic            ready_in   [3];
    logic            borrow_out [3];
    logic            busy_out   [3];
    logic [0:0]      diff_w1;
    logic [7:0]      diff_w8;
    logic [12:0]     diff_w13;

    int   checks = 0;
    int   errors = 0;
    exp_t sb0 [$];
    exp_t sb1 [$];
    exp_t sb2 [$];

    serial_subtractor #(.WIDTH(1)) u_w1 (
        .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in[0]), .ready_out(ready_out[0]),
        .a_in(a_in[0][0:0]), .b_in(b_in[0][0:0]), .valid_out(valid_out[0]),
        .ready_in(ready_in[0]), .diff_out(diff_w1), .borrow_out(borrow_out[0]),
        .busy_out(busy_out[0])
    );

    serial_subtractor #(.WIDTH(8)) u_w8 (
        .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in[1]), .ready_out(ready_out[1]),
        .a_in(a_in[1][7:0]), .b_in(b_in[1][7:0]), .valid_out(valid_out[1]),
        .ready_in(ready_in[1]), .diff_out(diff_w8), .borrow_out(borrow_out[1]),
        .busy_out(busy_out[1])
    );

    serial_subtractor #(.WIDTH(13)) u_w13 (
        .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in[2]), .ready_out(ready_out[2]),
        .a_in(a_in[2][12:0]), .b_in(b_in[2][12:0]), .valid_out(valid_out[2]),
        .ready_in(ready_in[2]), .diff_out(diff_w13), .borrow_out(borrow_out[2]),
        .busy_out(busy_out[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [MAXW-1:0] msk(int k);
        logic [MAXW:0] m;
        m = MW1'(1) << WS[k];
        return MAXW'(m - MW1'(1));
    endfunction

    function automatic logic [MAXW-1:0] dget(int k);
        case (k)
            0:       return MAXW'(diff_w1);
            1:       return MAXW'(diff_w8);
            default: return diff_w13;
        endcase
    endfunction

    task automatic qpush(int k, exp_t e);
        case (k)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    function automatic int qsize(int k);
        case (k)
            0:       return sb0.size();
            1:       return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    function automatic exp_t qpop(int k);
        case (k)
            0:       return sb0.pop_front();
            1:       return sb1.pop_front();
            default: return sb2.pop_front();
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset(int k, string tag);
        chk($sformatf("%s_ready%0d", tag, k),  32'(ready_out[k]),  32'd1);
        chk($sformatf("%s_valid%0d", tag, k),  32'(valid_out[k]),  32'd0);
        chk($sformatf("%s_busy%0d", tag, k),   32'(busy_out[k]),   32'd0);
        chk($sformatf("%s_diff%0d", tag, k),   32'(dget(k)),       32'd0);
        chk($sformatf("%s_borrow%0d", tag, k), 32'(borrow_out[k]), 32'd0);
    endtask

    // Drive one operand pair; returns one step past the accept edge. Caller is at posedge+1.
    task automatic issue(int k, logic [MAXW-1:0] a, logic [MAXW-1:0] b, bit track, bit rnd);
        int n;
        logic [MAXW-1:0] am;
        logic [MAXW-1:0] bm;
        exp_t e;
        n = 0;
        while (!ready_out[k]) begin
            if (rnd) begin
                ready_in[k] = ($urandom_range(0, 3) != 0);
                valid_in[k] = 1'($urandom_range(0, 1));
                a_in[k]     = MAXW'($urandom);
                b_in[k]     = MAXW'($urandom);
            end
            @(posedge clk);
            #1;
            n++;
            if (n > 300) begin
                chk($sformatf("ready_timeout%0d", k), 32'(n), 32'd0);
                return;
            end
        end
        if (rnd) ready_in[k] = ($urandom_range(0, 3) != 0);
        am          = a & msk(k);
        bm          = b & msk(k);
        a_in[k]     = am;
        b_in[k]     = bm;
        valid_in[k] = 1'b1;
        if (track) begin
            e.diff   = (am - bm) & msk(k);
            e.borrow = (am < bm);
            qpush(k, e);
        end
        @(posedge clk);
        #1;
        valid_in[k] = 1'b0;
        a_in[k]     = MAXW'($urandom);
        b_in[k]     = MAXW'($urandom);
    endtask

    task automatic wait_valid(int k, output int n);
        n = 0;
        while (!valid_out[k] && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_drain(int k);
        int n;
        n = 0;
        while ((qsize(k) != 0 || !ready_out[k]) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("drain%0d", k), 32'(qsize(k)), 32'd0);
    endtask

    task automatic rand_run(int k, int nops);
        for (int i = 0; i < nops; i++) begin
            repeat ($urandom_range(0, 2)) begin
                ready_in[k] = ($urandom_range(0, 3) != 0);
                @(posedge clk);
                #1;
            end
            issue(k, MAXW'($urandom), MAXW'($urandom), 1'b1, 1'b1);
        end
    endtask

    // Monitor: pops the scoreboard on every result transfer and checks handshake exclusivity
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("excl%0d", k),
                    32'((ready_out[k] && valid_out[k]) || (busy_out[k] && (ready_out[k] || valid_out[k]))),
                    32'd0);
                if (valid_out[k] && ready_in[k]) begin
                    if (qsize(k) == 0) begin
                        chk($sformatf("unexpected_result%0d", k), 32'(dget(k)), 32'hFFFF_FFFF);
                    end else begin
                        e = qpop(k);
                        chk($sformatf("diff%0d", k),   32'(dget(k)),       32'(e.diff));
                        chk($sformatf("borrow%0d", k), 32'(borrow_out[k]), 32'(e.borrow));
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            valid_in[k] = 1'b0;
            ready_in[k] = 1'b0;
            a_in[k]     = '0;
            b_in[k]     = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk_reset(k, "por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency and basic result on the 8-bit instance
        ready_in[1] = 1'b1;
        issue(1, 13'h5A, 13'h23, 1'b1, 1'b0);
        chk("busy_run", 32'(busy_out[1]), 32'd1);
        chk("ready_run", 32'(ready_out[1]), 32'd0);
        wait_valid(1, n);
        chk("lat8", 32'(n), 32'd8);
        chk("lat8_diff", 32'(diff_w8), 32'h37);
        @(posedge clk);
        #1;
        chk("ready_after_take", 32'(ready_out[1]), 32'd1);
        chk("valid_after_take", 32'(valid_out[1]), 32'd0);

        issue(1, 13'h10, 13'h20, 1'b1, 1'b0);
        issue(1, 13'h00, 13'h01, 1'b1, 1'b0);
        issue(1, 13'hA5, 13'hA5, 1'b1, 1'b0);
        wait_drain(1);

        // Backpressure with ignored valid_in pulses in RUN and DONE
        ready_in[1] = 1'b0;
        issue(1, 13'hFF, 13'h01, 1'b1, 1'b0);
        valid_in[1] = 1'b1;
        a_in[1]     = 13'h33;
        b_in[1]     = 13'h44;
        @(posedge clk);
        #1;
        valid_in[1] = 1'b0;
        wait_valid(1, n);
        chk("bp_lat", 32'(n), 32'd7);
        for (int i = 0; i < 5; i++) begin
            valid_in[1] = (i == 2);
            a_in[1]     = 13'h12;
            b_in[1]     = 13'h34;
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(valid_out[1]), 32'd1);
            chk("bp_diff", 32'(diff_w8), 32'hFE);
            chk("bp_borrow", 32'(borrow_out[1]), 32'd0);
        end
        valid_in[1] = 1'b0;
        ready_in[1] = 1'b1;
        wait_drain(1);

        // Reset after three bits of an in-flight operation
        issue(1, 13'h12, 13'h34, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk_reset(1, "midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(1, 13'h80, 13'h01, 1'b1, 1'b0);
        wait_drain(1);

        // WIDTH=1 exhaustive
        ready_in[0] = 1'b1;
        for (int ab = 0; ab < 4; ab++) begin
            issue(0, MAXW'(ab >> 1), MAXW'(ab & 1), 1'b1, 1'b0);
            wait_valid(0, n);
            chk($sformatf("lat1_%0d", ab), 32'(n), 32'd1);
        end
        wait_drain(0);

        fork
            rand_run(0, 200);
            rand_run(1, 1000);
            rand_run(2, 1000);
        join
        for (int k = 0; k < 3; k++) ready_in[k] = 1'b1;
        for (int k = 0; k < 3; k++) wait_drain(k);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
